// File: rtl/auto_test_pkg.sv
// Shared constants, stream-select type and expected-pattern helper for the
// DCFEB auto-test readback checker.
package auto_test_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic [15:0] DAQ_SEED_DEF = 16'h0000;
    localparam logic [15:0] TRG_SEED_DEF = 16'hA5A5;

    typedef enum logic {
        STRM_DAQ = 1'b0,
        STRM_TRG = 1'b1
    } strm_e;

    // Low DATA_W bits of {DATA_W/2{~addr}, DATA_W/2{addr}} XOR seed; bits at and
    // above data_w are forced to zero so callers can compare zero-extended data.
    function automatic logic [31:0] exp_word(input logic [31:0] addr,
                                             input logic [31:0] seed,
                                             input int          addr_w,
                                             input int          data_w);
        logic [31:0] w;
        logic [4:0]  idx;
        int          half_bits;
        w         = 32'h0000_0000;
        half_bits = (data_w / 2) * addr_w;
        for (int j = 0; j < 32; j++) begin
            if (j < data_w) begin
                if (j < half_bits) begin
                    idx  = 5'(j % addr_w);
                    w[j] = addr[idx] ^ seed[j];
                end else begin
                    idx  = 5'((j - half_bits) % addr_w);
                    w[j] = ~addr[idx] ^ seed[j];
                end
            end else begin
                w[j] = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/auto_test_err_cnt.sv
// Saturating per-stream mismatch counter with a latch port that folds in the
// same-cycle pending increment before publishing the count.
module auto_test_err_cnt
    import auto_test_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             inc,
    input  logic             latch,
    output logic [CNT_W-1:0] errs,
    output logic             latch_nz
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] run_r;
    logic [CNT_W-1:0] sum_s;
    logic [CNT_W-1:0] errs_r;

    // Running count plus this cycle's increment, held at the ceiling.
    always_comb begin
        sum_s = run_r;
        if (inc && (run_r != CNT_MAX)) begin
            sum_s = run_r + CNT_W'(1);
        end else begin
            sum_s = run_r;
        end
    end

    // Running counter; a latch hands the total to errs_r and restarts at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_r <= {CNT_W{1'b0}};
        end else if (clr || latch) begin
            run_r <= {CNT_W{1'b0}};
        end else begin
            run_r <= sum_s;
        end
    end

    // Published count survives address clears; only reset or a new latch changes it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            errs_r <= {CNT_W{1'b0}};
        end else if (latch) begin
            errs_r <= sum_s;
        end else begin
            errs_r <= errs_r;
        end
    end

    assign errs     = errs_r;
    assign latch_nz = (sum_s != {CNT_W{1'b0}});

endmodule

// File: rtl/auto_test_rbk_checker.sv
// Responder side of the DCFEB auto-test readback handshake.
// Optional first-error capture ports are enabled by AUTO_TEST_FIRST_ERR_EN.
module auto_test_rbk_checker
    import auto_test_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter logic [15:0] DAQ_SEED = DAQ_SEED_DEF,
    parameter logic [15:0] TRG_SEED = TRG_SEED_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR_ADDR,
    input  logic              INCR,
    input  logic              DAQ_CHK,
    input  logic              TRG_CHK,
    input  logic              UPDATE,
    input  logic              USE_TEST_DATA,
    input  logic [DATA_W-1:0] RBK_DATA,
    output logic [ADDR_W-1:0] RBK_ADDR,
    output logic [CNT_W-1:0]  DAQ_ERRS,
    output logic [CNT_W-1:0]  TRG_ERRS,
    output logic              ERR_FLAG,
    output logic              CHK_BUSY
`ifdef AUTO_TEST_FIRST_ERR_EN
    ,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
    output logic [DATA_W-1:0] FIRST_ERR_DATA,
    output logic              FIRST_ERR_TRG,
    output logic              FIRST_ERR_VLD
`endif
);

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] p_addr_r;
    strm_e             p_trg_r;
    logic              p_vld_r;
    logic              err_flag_r;
    logic              strobe_s;
    logic [31:0]       exp_s;
    logic              mis_s;
    logic              inc_daq_s;
    logic              inc_trg_s;
    logic              upd_daq_s;
    logic              upd_trg_s;
    logic              daq_nz_s;
    logic              trg_nz_s;

    assign strobe_s = INCR & (DAQ_CHK | TRG_CHK) & USE_TEST_DATA;

    // Readback address: clear beats increment, wraps naturally at 2^ADDR_W.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (CLR_ADDR) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (INCR) begin
            addr_r <= addr_r + ADDR_W'(1);
        end else begin
            addr_r <= addr_r;
        end
    end

    // Stage 0: remember which address/stream the buffer word arriving next belongs to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_vld_r  <= 1'b0;
            p_addr_r <= {ADDR_W{1'b0}};
            p_trg_r  <= STRM_DAQ;
        end else if (CLR_ADDR) begin
            p_vld_r  <= 1'b0;
            p_addr_r <= {ADDR_W{1'b0}};
            p_trg_r  <= STRM_DAQ;
        end else if (strobe_s) begin
            p_vld_r  <= 1'b1;
            p_addr_r <= addr_r;
            p_trg_r  <= TRG_CHK ? STRM_TRG : STRM_DAQ;
        end else begin
            p_vld_r  <= 1'b0;
            p_addr_r <= p_addr_r;
            p_trg_r  <= p_trg_r;
        end
    end

    // Stage 1: compare the returned word against the stream's pattern.
    always_comb begin
        exp_s = exp_word(32'(p_addr_r),
                         (p_trg_r == STRM_TRG) ? 32'(TRG_SEED) : 32'(DAQ_SEED),
                         ADDR_W, DATA_W);
        mis_s = p_vld_r & (32'(RBK_DATA) != exp_s);
    end

    // A clear drops any result completing in the same cycle.
    assign inc_daq_s = mis_s & (p_trg_r == STRM_DAQ) & ~CLR_ADDR;
    assign inc_trg_s = mis_s & (p_trg_r == STRM_TRG) & ~CLR_ADDR;
    assign upd_daq_s = UPDATE & ~TRG_CHK;
    assign upd_trg_s = UPDATE & TRG_CHK;

    auto_test_err_cnt #(.CNT_W(CNT_W)) u_daq_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (CLR_ADDR),
        .inc      (inc_daq_s),
        .latch    (upd_daq_s),
        .errs     (DAQ_ERRS),
        .latch_nz (daq_nz_s)
    );

    auto_test_err_cnt #(.CNT_W(CNT_W)) u_trg_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (CLR_ADDR),
        .inc      (inc_trg_s),
        .latch    (upd_trg_s),
        .errs     (TRG_ERRS),
        .latch_nz (trg_nz_s)
    );

    // Sticky error flag, raised by any nonzero latch and dropped by CLR_ADDR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_flag_r <= 1'b0;
        end else if (CLR_ADDR) begin
            err_flag_r <= 1'b0;
        end else if ((upd_daq_s && daq_nz_s) || (upd_trg_s && trg_nz_s)) begin
            err_flag_r <= 1'b1;
        end else begin
            err_flag_r <= err_flag_r;
        end
    end

    assign RBK_ADDR = addr_r;
    assign ERR_FLAG = err_flag_r;
    assign CHK_BUSY = p_vld_r;

`ifdef AUTO_TEST_FIRST_ERR_EN
    logic [ADDR_W-1:0] fe_addr_r;
    logic [DATA_W-1:0] fe_data_r;
    logic              fe_trg_r;
    logic              fe_vld_r;

    // First mismatch after a clear is frozen until the next clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fe_addr_r <= {ADDR_W{1'b0}};
            fe_data_r <= {DATA_W{1'b0}};
            fe_trg_r  <= 1'b0;
            fe_vld_r  <= 1'b0;
        end else if (CLR_ADDR) begin
            fe_addr_r <= {ADDR_W{1'b0}};
            fe_data_r <= {DATA_W{1'b0}};
            fe_trg_r  <= 1'b0;
            fe_vld_r  <= 1'b0;
        end else if (mis_s && !fe_vld_r) begin
            fe_addr_r <= p_addr_r;
            fe_data_r <= RBK_DATA;
            fe_trg_r  <= (p_trg_r == STRM_TRG);
            fe_vld_r  <= 1'b1;
        end else begin
            fe_addr_r <= fe_addr_r;
            fe_data_r <= fe_data_r;
            fe_trg_r  <= fe_trg_r;
            fe_vld_r  <= fe_vld_r;
        end
    end

    assign FIRST_ERR_ADDR = fe_addr_r;
    assign FIRST_ERR_DATA = fe_data_r;
    assign FIRST_ERR_TRG  = fe_trg_r;
    assign FIRST_ERR_VLD  = fe_vld_r;
`endif

endmodule

// File: tb/tb_auto_test_rbk_checker.sv
// Directed bench for auto_test_rbk_checker: a default-width instance and a
// CNT_W=2 instance share stimulus and a 16-word synchronous readback buffer.
module tb_auto_test_rbk_checker;

    logic        clk;
    logic        rst_n;
    logic        clr_addr;
    logic        incr;
    logic        daq_chk;
    logic        trg_chk;
    logic        update;
    logic        use_td;
    logic [15:0] rbk_data;
    logic [3:0]  rbk_addr;
    logic [3:0]  rbk_addr_c2;
    logic [7:0]  daq_errs;
    logic [7:0]  trg_errs;
    logic [1:0]  daq_errs_c2;
    logic [1:0]  trg_errs_c2;
    logic        err_flag;
    logic        err_flag_c2;
    logic        chk_busy;
    logic        chk_busy_c2;
    logic [15:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef AUTO_TEST_FIRST_ERR_EN
    logic [3:0]  fe_addr;
    logic [15:0] fe_data;
    logic        fe_trg;
    logic        fe_vld;
    logic [3:0]  fe_addr_c2;
    logic [15:0] fe_data_c2;
    logic        fe_trg_c2;
    logic        fe_vld_c2;
`endif

    auto_test_rbk_checker u_dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .CLR_ADDR      (clr_addr),
        .INCR          (incr),
        .DAQ_CHK       (daq_chk),
        .TRG_CHK       (trg_chk),
        .UPDATE        (update),
        .USE_TEST_DATA (use_td),
        .RBK_DATA      (rbk_data),
        .RBK_ADDR      (rbk_addr),
        .DAQ_ERRS      (daq_errs),
        .TRG_ERRS      (trg_errs),
        .ERR_FLAG      (err_flag),
        .CHK_BUSY      (chk_busy)
`ifdef AUTO_TEST_FIRST_ERR_EN
        ,
        .FIRST_ERR_ADDR (fe_addr),
        .FIRST_ERR_DATA (fe_data),
        .FIRST_ERR_TRG  (fe_trg),
        .FIRST_ERR_VLD  (fe_vld)
`endif
    );

    auto_test_rbk_checker #(.CNT_W(2)) u_dut_c2 (
        .CLK           (clk),
        .RST_N         (rst_n),
        .CLR_ADDR      (clr_addr),
        .INCR          (incr),
        .DAQ_CHK       (daq_chk),
        .TRG_CHK       (trg_chk),
        .UPDATE        (update),
        .USE_TEST_DATA (use_td),
        .RBK_DATA      (rbk_data),
        .RBK_ADDR      (rbk_addr_c2),
        .DAQ_ERRS      (daq_errs_c2),
        .TRG_ERRS      (trg_errs_c2),
        .ERR_FLAG      (err_flag_c2),
        .CHK_BUSY      (chk_busy_c2)
`ifdef AUTO_TEST_FIRST_ERR_EN
        ,
        .FIRST_ERR_ADDR (fe_addr_c2),
        .FIRST_ERR_DATA (fe_data_c2),
        .FIRST_ERR_TRG  (fe_trg_c2),
        .FIRST_ERR_VLD  (fe_vld_c2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous buffer: one-cycle read latency from the registered address.
    always @(posedge clk) rbk_data <= mem[rbk_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // With DATA_W=16, ADDR_W=4 the truncated pattern is the address repeated four times.
    function automatic logic [15:0] tb_exp(input logic [3:0] a, input logic [15:0] seed);
        return {a, a, a, a} ^ seed;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic i, input logic d, input logic t, input logic u);
        clr_addr = c; incr = i; daq_chk = d; trg_chk = t; update = u;
        @(posedge clk);
        #1;
        clr_addr = 1'b0; incr = 1'b0; daq_chk = 1'b0; trg_chk = 1'b0; update = 1'b0;
    endtask

    task automatic load(input logic [15:0] seed, input logic [15:0] cmask);
        for (int a = 0; a < 16; a++) begin
            mem[a] = tb_exp(4'(a), seed) ^ (cmask[a] ? 16'h0100 : 16'h0000);
        end
    endtask

    // CLR, 3 plain INCRs, 10 checked INCRs (addresses 3..12), optional UPDATE.
    task automatic run_pass(input logic trg, input logic use_v, input logic do_upd);
        use_td = use_v;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("clr_addr", 32'(rbk_addr), 32'd0);
        check_eq("clr_flag", 32'(err_flag), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, ~trg, trg, 1'b0);
            if (k == 0) check_eq("busy_strobe", 32'(chk_busy), 32'(use_v));
        end
        if (do_upd) begin
            step(1'b0, 1'b0, ~trg, trg, 1'b1);
            check_eq("busy_idle", 32'(chk_busy), 32'd0);
        end
        check_eq("addr_end", 32'(rbk_addr), 32'd13);
        check_eq("addr_end_c2", 32'(rbk_addr_c2), 32'd13);
        use_td = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clr_addr = 1'b0; incr = 1'b0; daq_chk = 1'b0;
        trg_chk = 1'b0; update = 1'b0; use_td = 1'b1;
        load(16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_addr", 32'(rbk_addr), 32'd0);
        check_eq("rst_daq", 32'(daq_errs), 32'd0);
        check_eq("rst_trg", 32'(trg_errs), 32'd0);
        check_eq("rst_flag", 32'(err_flag), 32'd0);
        check_eq("rst_busy", 32'(chk_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean DAQ pass.
        run_pass(1'b0, 1'b1, 1'b1);
        check_eq("p1_daq", 32'(daq_errs), 32'd0);
        check_eq("p1_flag", 32'(err_flag), 32'd0);

        // Words 5 and 12 corrupted; 12 completes in the UPDATE cycle.
        load(16'h0000, 16'h1020);
        run_pass(1'b0, 1'b1, 1'b1);
        check_eq("p2_daq", 32'(daq_errs), 32'd2);
        check_eq("p2_daq_c2", 32'(daq_errs_c2), 32'd2);
        check_eq("p2_flag", 32'(err_flag), 32'd1);

        // TRG pass, word 8 corrupted; DAQ latch must survive the clear.
        load(16'hA5A5, 16'h0100);
        run_pass(1'b1, 1'b1, 1'b1);
        check_eq("p3_trg", 32'(trg_errs), 32'd1);
        check_eq("p3_daq_kept", 32'(daq_errs), 32'd2);
        check_eq("p3_flag", 32'(err_flag), 32'd1);

        // Compare disabled, every word corrupted.
        load(16'h0000, 16'hFFFF);
        run_pass(1'b0, 1'b0, 1'b1);
        check_eq("p5_daq", 32'(daq_errs), 32'd0);
        check_eq("p5_daq_c2", 32'(daq_errs_c2), 32'd0);
        check_eq("p5_flag", 32'(err_flag), 32'd0);
        check_eq("p5_trg_kept", 32'(trg_errs), 32'd1);

        // Six corrupted words: 8-bit counter reads 6, 2-bit counter sticks at 3.
        load(16'h0000, 16'h01F8);
        run_pass(1'b0, 1'b1, 1'b1);
        check_eq("p4_daq", 32'(daq_errs), 32'd6);
        check_eq("p4_daq_sat", 32'(daq_errs_c2), 32'd3);
        check_eq("p4_flag_c2", 32'(err_flag_c2), 32'd1);

        // Mid-pass reset with errors at 7 and 9 already counted.
        load(16'h0000, 16'h0280);
        run_pass(1'b0, 1'b1, 1'b0);
        check_eq("p6_daq_hold", 32'(daq_errs), 32'd6);
`ifdef AUTO_TEST_FIRST_ERR_EN
        check_eq("fe_addr", 32'(fe_addr), 32'd7);
        check_eq("fe_data", 32'(fe_data), 32'h7677);
        check_eq("fe_trg", 32'(fe_trg), 32'd0);
        check_eq("fe_vld", 32'(fe_vld), 32'd1);
`endif
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_addr", 32'(rbk_addr), 32'd0);
        check_eq("mid_rst_daq", 32'(daq_errs), 32'd0);
        check_eq("mid_rst_daq_c2", 32'(daq_errs_c2), 32'd0);
        check_eq("mid_rst_trg", 32'(trg_errs), 32'd0);
        check_eq("mid_rst_busy", 32'(chk_busy), 32'd0);
`ifdef AUTO_TEST_FIRST_ERR_EN
        check_eq("mid_rst_fe_addr", 32'(fe_addr), 32'd0);
        check_eq("mid_rst_fe_data", 32'(fe_data), 32'd0);
        check_eq("mid_rst_fe_vld", 32'(fe_vld), 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("post_rst_daq", 32'(daq_errs), 32'd0);
        check_eq("post_rst_flag", 32'(err_flag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_test_rbk_checker.md
Name: auto_test_rbk_checker

Overview:
- Responder side of the DCFEB auto-test readback handshake.
- Consumes the controller's CLR_ADDR / INCR / DAQ_CHK / TRG_CHK / UPDATE / USE_TEST_DATA strobes.
- Drives the readback buffer address, compares returned words against the known test pattern, and accumulates per-stream (DAQ, TRG) mismatch counts.
- Publishes latched counts on UPDATE for slow-control readout.

Parameters:
- DATA_W, 16, readback word width (8..32).
- ADDR_W, 4, readback buffer address width.
- CNT_W, 8, error counter width (saturating).
- DAQ_SEED, 16'h0000, XOR seed for the DAQ-stream expected pattern.
- TRG_SEED, 16'hA5A5, XOR seed for the TRG-stream expected pattern.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CLR_ADDR  in  1  clear address and compare pipeline; discard pending accumulation.
- INCR  in  1  advance address; if DAQ_CHK|TRG_CHK, also a check strobe.
- DAQ_CHK  in  1  current strobe belongs to the DAQ stream.
- TRG_CHK  in  1  current strobe belongs to the TRG stream.
- UPDATE  in  1  latch the running count of the selected stream to its output.
- USE_TEST_DATA  in  1  compare enable; low suppresses all error counting.
- RBK_DATA  in  DATA_W  buffer read data, 1-cycle synchronous read latency after RBK_ADDR.
- RBK_ADDR  out  ADDR_W  buffer read address (registered).
- DAQ_ERRS  out  CNT_W  latched DAQ mismatch count.
- TRG_ERRS  out  CNT_W  latched TRG mismatch count.
- ERR_FLAG  out  1  sticky: any nonzero count was latched since last CLR_ADDR.
- CHK_BUSY  out  1  a compare is in the pipeline stage.

Behaviour:
- Reset: RBK_ADDR=0, DAQ_ERRS=0, TRG_ERRS=0, ERR_FLAG=0, CHK_BUSY=0. Running counters and pipeline regs are 0.
- Address:
  - CLR_ADDR sets RBK_ADDR=0 next cycle.
  - INCR (without CLR_ADDR) sets RBK_ADDR+1 with mod-2^ADDR_W wrap.
  - CLR_ADDR wins when both are asserted.
- Expected word: EXP(a,seed) = ({DATA_W/2{~a}},{DATA_W/2{a}} truncated to DATA_W) XOR seed. TRG_SEED is used when TRG_CHK, else DAQ_SEED.
- Stage 0, on a check strobe (INCR & (DAQ_CHK|TRG_CHK) & USE_TEST_DATA):
  - capture p_addr=RBK_ADDR, p_trg=TRG_CHK, p_vld=1. This sets CHK_BUSY=1 next cycle.
  - INCR with neither CHK flag only moves the address.
- Stage 1 (p_vld), in the cycle after the strobe:
  - RBK_DATA is valid for p_addr.
  - mismatch = (RBK_DATA != EXP(p_addr, seed(p_trg))).
  - A mismatch increments run_trg or run_daq, saturating at 2^CNT_W-1.
- DAQ_CHK and TRG_CHK both high: TRG_CHK takes precedence.
- UPDATE:
  - With TRG_CHK: TRG_ERRS <= run_trg + pending. Otherwise DAQ_ERRS <= run_daq + pending.
  - pending is the stage-1 mismatch of the same stream in the same cycle, and is bypassed in with saturation. The strobe immediately preceding UPDATE must be counted.
  - The selected running counter clears to 0 in the same cycle.
  - ERR_FLAG is set if the latched value is nonzero.
- CLR_ADDR:
  - clears p_vld and both running counters (a concurrent stage-1 result is dropped).
  - clears ERR_FLAG.
  - does not clear the latched DAQ_ERRS/TRG_ERRS.
- USE_TEST_DATA low: no new strobes enter stage 0; an already-captured stage-1 compare still completes.
- RST_N low mid-pass: all state returns to reset values immediately; no partial count survives.
- Latency: strobe to running-counter update is 1 cycle; UPDATE to latched output is 1 cycle.

Optional Feature:
- Macro AUTO_TEST_FIRST_ERR_EN.
- When defined: add outputs FIRST_ERR_ADDR[ADDR_W], FIRST_ERR_DATA[DATA_W], FIRST_ERR_TRG[1], FIRST_ERR_VLD[1].
  - On the first stage-1 mismatch after CLR_ADDR or reset, capture p_addr, RBK_DATA and p_trg, and set VLD.
  - Hold all of them until the next CLR_ADDR, which clears them to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package auto_test_pkg holds:
  - default DATA_W/ADDR_W/CNT_W constants;
  - DAQ_SEED/TRG_SEED constants;
  - a stream-select typedef (STRM_DAQ=0, STRM_TRG=1);
  - the function exp_word(addr, seed).
- One natural sub-module, auto_test_err_cnt: a saturating counter with a bypass-add latch port, instantiated twice (DAQ, TRG).

Test Plan:
- Reset release, buffer loaded with EXP(a,DAQ_SEED) for all a; controller sequence CLR_ADDR, 3x INCR, 10x INCR+DAQ_CHK, UPDATE+DAQ_CHK -> DAQ_ERRS=0, ERR_FLAG=0, RBK_ADDR=13.
- Same sequence with words 5 and 12 corrupted -> DAQ_ERRS=2 one cycle after UPDATE; ERR_FLAG=1. Word 12 is the last strobe and exercises the bypass.
- Second pass on the TRG stream with TRG_SEED data and one corrupted word -> TRG_ERRS=1; DAQ_ERRS keeps its prior value of 2.
- CNT_W=2, 6 corrupted words -> count saturates at 3 with no wrap to 0.
- USE_TEST_DATA=0 throughout a pass with all words corrupted -> counts stay 0; RBK_ADDR still advances to 13.
- AUTO_TEST_FIRST_ERR_EN defined, corruptions at addresses 7 and 9, then RST_N pulsed mid-pass -> FIRST_ERR_ADDR=7 before the pulse; all outputs 0 after it.
